// File: rtl/monitor_slot_pkg.sv
// monitor_slot_pkg: FSM states, bus command/register codes and default serial bytes for monitor_slot_if
package monitor_slot_pkg;
  typedef enum logic [2:0] {IDLE, GET_REG, INIT_REG, INIT_DATA, SUB_REG, SUB_DATA, WAIT_NEXT} state_t;
  typedef enum logic [1:0] {SEL_ID, SEL_VIDEO, SEL_SERIAL} sel_t;
  localparam logic [7:0] CMD_GET = 8'hFF;
  localparam logic [7:0] CMD_INIT = 8'h10;
  localparam logic [3:0] N_ID = 4'h0;
  localparam logic [3:0] N_VIDEO = 4'h1;
  localparam logic [3:0] N_SERIAL = 4'h3;
  localparam logic [7:0] REG_SLOT = 8'h03;
  localparam logic [7:0] REG_IRQ_ST = 8'h41;
  localparam logic [7:0] REG_IRQ_MASK = 8'h42;
  localparam logic [7:0] REG_CSPACE = 8'h00;
  localparam logic [7:0] REG_VCTRL = 8'h10;
  localparam logic [7:0] CS_RGB = 8'h04;
  localparam logic [7:0] SERIAL_PAD = 8'h30;
  localparam logic [7:0] READ_NONE = 8'hFF;
  localparam logic [15:0][7:0] SERIAL_DEF = {{9{8'h30}}, 8'h31, 8'h34, 8'h32, 8'h30, 8'h32, 8'h53, 8'h4D};
endpackage

// File: rtl/monitor_slot_irq.sv
// monitor_slot_irq: interrupt pending/mask registers with write-1-to-clear and video-format change detection
module monitor_slot_irq
  import monitor_slot_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int FMT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_set,
  input  logic [FMT_W-1:0]   video_format,
  input  logic               wr_status,
  input  logic               wr_mask,
  input  logic [7:0]         wdata,
  output logic [7:0]         status,
  output logic [7:0]         mask_rd,
  output logic               int_x
);
  logic [NUM_IRQ-1:0] pending, mask, fmt_vec;
  logic [FMT_W-1:0] fmt_s, fmt_p, fmt_q;
  logic fmt_evt;
  assign fmt_evt = (fmt_s == fmt_p) && (fmt_s != fmt_q);
  assign fmt_vec = NUM_IRQ'(fmt_evt) << 5;
  assign status = ~8'(pending);
  assign mask_rd = 8'(mask);
  assign int_x = ~|(pending & mask);
  // new sets win over a same-cycle clear; a format counts once it has been seen twice in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      fmt_s <= '0;
      fmt_p <= '0;
      fmt_q <= '0;
      pending <= '0;
      mask <= '1;
    end else begin
      fmt_s <= video_format;
      fmt_p <= fmt_s;
      if (fmt_evt) fmt_q <= fmt_s;
      pending <= (pending & ~(wr_status ? wdata[NUM_IRQ-1:0] : '0)) | irq_set | fmt_vec;
      if (wr_mask) mask <= wdata[NUM_IRQ-1:0];
    end
  end
endmodule

// File: rtl/monitor_slot_if.sv
// monitor_slot_if: slot bus slave with init/ID/video/serial registers; MONITOR_SLOT_IF_TIMEOUT_EN adds a stall watchdog
module monitor_slot_if
  import monitor_slot_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = 8'h88,
  parameter int SERIAL_LEN = 7,
  parameter int NUM_IRQ = 8,
  parameter int FMT_W = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic               clk_50mhz_in,
  input  logic               reset,
  input  logic               clk_rw,
  input  logic               ax_d,
  input  logic               r_wx,
  input  logic               slot_x_int_x,
  input  logic [7:0]         data_in_x,
  input  logic [NUM_IRQ-1:0] irq_set,
  input  logic [FMT_W-1:0]   video_format,
  output logic [7:0]         data_out,
  output logic               data_oe_x,
  output logic               int_x,
  output logic               rgb_comp_x,
  output logic               int_ext_x,
  output logic               video_oe_x,
  output logic               hd_sd_x
);
  if (SERIAL_LEN < 1 || SERIAL_LEN > 16 || NUM_IRQ < 1 || NUM_IRQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("monitor_slot_if: parameter out of range");
  end
  state_t state, state_nxt;
  sel_t sel, sel_nxt;
  logic [11:0] sync1, sync2;
  logic rw_q, samp, ax_s, rd_s, slot_s, addr_cyc, data_cyc, sel_ok, wd_exp;
  logic data_oe, video_oe, oe_nxt, wr_init, wr_sub, wr_status, wr_mask;
  logic [7:0] data_in, reg_addr, rd_val, init_val, vid_val, ser_val, status, mask_rd;
  logic [3:0] slot_no;
  assign {ax_s, rd_s, slot_s} = sync2[10:8];
  assign data_in = ~sync2[7:0];
  assign addr_cyc = samp & ~ax_s;
  assign data_cyc = samp & ax_s;
  assign sel_ok = data_in[3:0] inside {N_ID, N_VIDEO, N_SERIAL};
  assign sel_nxt = data_in[3:0] == N_VIDEO ? SEL_VIDEO : data_in[3:0] == N_SERIAL ? SEL_SERIAL : SEL_ID;
  assign data_oe_x = ~(data_oe & rd_s & ax_s & ~reset);
  assign video_oe_x = ~video_oe;
  assign hd_sd_x = ~(video_format == FMT_W'(1) || video_format == FMT_W'(2));
  // bus inputs cross into clk domain; a cycle is taken one clock after the strobe's rising edge
  always_ff @(posedge clk_50mhz_in) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      rw_q <= 1'b0;
      samp <= 1'b0;
    end else begin
      sync1 <= {clk_rw, ax_d, r_wx, slot_x_int_x, data_in_x};
      sync2 <= sync1;
      rw_q <= sync2[11];
      samp <= sync2[11] & ~rw_q;
    end
  end
`ifdef MONITOR_SLOT_IF_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  assign wd_exp = wd_cnt == WD_W'(TIMEOUT_CYC - 1);
  // counts strobe-free cycles while a transfer is open
  always_ff @(posedge clk_50mhz_in) begin
    if (reset || samp || state == IDLE) wd_cnt <= '0;
    else if (!wd_exp) wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_exp = 1'b0;
`endif
  // state register
  always_ff @(posedge clk_50mhz_in) state <= reset ? IDLE : state_nxt;
  // transfer sequencing: address cycles open or abort transfers, data cycles advance them
  always_comb begin
    state_nxt = state;
    if (addr_cyc)
      state_nxt = (data_in == CMD_GET && rd_s) ? GET_REG :
                  (data_in == CMD_INIT && !rd_s && !slot_s && state == IDLE) ? INIT_REG : IDLE;
    else if (data_cyc)
      case (state)
        GET_REG:  state_nxt = (data_in[7:4] == slot_no && sel_ok) ? SUB_REG : WAIT_NEXT;
        INIT_REG: state_nxt = rd_s ? INIT_REG : INIT_DATA;
        SUB_REG:  state_nxt = rd_s ? SUB_REG : SUB_DATA;
        default:  state_nxt = state;
      endcase
    else if (wd_exp)
      state_nxt = IDLE;
  end
  // read mux and write strobes for the cycle being sampled
  always_comb begin
    wr_init = data_cyc && !rd_s && state == INIT_DATA;
    wr_sub = data_cyc && !rd_s && state == SUB_DATA && sel == SEL_VIDEO;
    wr_status = wr_init && reg_addr == REG_IRQ_ST;
    wr_mask = wr_init && reg_addr == REG_IRQ_MASK;
    oe_nxt = data_cyc && rd_s && (state == INIT_DATA || state == SUB_REG || state == SUB_DATA);
    ser_val = reg_addr < 8'(SERIAL_LEN) ? SERIAL_DEF[reg_addr[3:0]] : SERIAL_PAD;
    init_val = reg_addr == REG_IRQ_ST ? status : reg_addr == REG_IRQ_MASK ? mask_rd : READ_NONE;
    vid_val = reg_addr == REG_CSPACE ? (rgb_comp_x ? 8'h00 : CS_RGB) :
              reg_addr == REG_VCTRL ? {4'h0, video_oe, 2'b00, int_ext_x} : READ_NONE;
    rd_val = state == INIT_DATA ? init_val : sel == SEL_ID ? ID_VALUE : sel == SEL_SERIAL ? ser_val : vid_val;
  end
  // read data, drive enable, latched selection/register address and slot/video controls
  always_ff @(posedge clk_50mhz_in) begin
    if (reset) begin
      data_out <= READ_NONE;
      data_oe <= 1'b0;
      slot_no <= '0;
      sel <= SEL_ID;
      reg_addr <= '0;
      rgb_comp_x <= 1'b0;
      int_ext_x <= 1'b0;
      video_oe <= 1'b1;
    end else begin
      if (samp) begin
        data_out <= oe_nxt ? rd_val : READ_NONE;
        data_oe <= oe_nxt;
      end else if (wd_exp) data_oe <= 1'b0;
      if (data_cyc && !rd_s && (state == INIT_REG || state == SUB_REG)) reg_addr <= data_in;
      if (data_cyc && state == GET_REG) sel <= sel_nxt;
      if (wr_init && reg_addr == REG_SLOT) slot_no <= data_in[3:0];
      if (wr_sub && reg_addr == REG_CSPACE) rgb_comp_x <= data_in != CS_RGB;
      if (wr_sub && reg_addr == REG_VCTRL) begin
        int_ext_x <= data_in[0];
        video_oe <= data_in[3];
      end
    end
  end
  monitor_slot_irq #(.NUM_IRQ(NUM_IRQ), .FMT_W(FMT_W)) u_irq (
    .clk(clk_50mhz_in),
    .rst(reset),
    .irq_set(irq_set),
    .video_format(video_format),
    .wr_status(wr_status),
    .wr_mask(wr_mask),
    .wdata(data_in),
    .status(status),
    .mask_rd(mask_rd),
    .int_x(int_x)
  );
endmodule

// File: tb/tb_monitor_slot_if.sv
// tb_monitor_slot_if: scoreboarded bus-level bench for monitor_slot_if
module tb_monitor_slot_if;
  logic clk = 1'b0, reset = 1'b1, clk_rw = 1'b0, ax_d = 1'b0, r_wx = 1'b0, slot_x_int_x = 1'b0;
  logic [7:0] data_in_x = 8'hFF, irq_set = 8'h00, video_format = 8'h00, data_out;
  logic data_oe_x, int_x, rgb_comp_x, int_ext_x, video_oe_x, hd_sd_x;
  int checks = 0, errors = 0;
  logic [7:0] exp_q [$];
  always #10 clk = ~clk;
  monitor_slot_if dut (
    .clk_50mhz_in(clk),
    .reset(reset),
    .clk_rw(clk_rw),
    .ax_d(ax_d),
    .r_wx(r_wx),
    .slot_x_int_x(slot_x_int_x),
    .data_in_x(data_in_x),
    .irq_set(irq_set),
    .video_format(video_format),
    .data_out(data_out),
    .data_oe_x(data_oe_x),
    .int_x(int_x),
    .rgb_comp_x(rgb_comp_x),
    .int_ext_x(int_ext_x),
    .video_oe_x(video_oe_x),
    .hd_sd_x(hd_sd_x)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic bus(input string tag, input logic ax, input logic rd, input logic [7:0] d,
                     input logic [7:0] pulse, input int exp);
    ax_d = ax;
    r_wx = rd;
    data_in_x = ~d;
    if (exp >= 0) exp_q.push_back(8'(exp));
    repeat (2) @(negedge clk);
    clk_rw = 1'b1;
    repeat (3) @(negedge clk);
    irq_set = pulse;
    @(negedge clk);
    irq_set = 8'h00;
    repeat (2) @(negedge clk);
    if (exp >= 0) begin
      check({tag, " data"}, data_out, exp_q.pop_front());
      check({tag, " oe_x"}, data_oe_x, 1'b0);
    end
    clk_rw = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic wr(input logic [7:0] d);
    bus("wr", 1'b1, 1'b0, d, 8'h00, -1);
  endtask
  task automatic rd(input string tag, input logic [7:0] exp);
    bus(tag, 1'b1, 1'b1, 8'h00, 8'h00, int'(exp));
  endtask
  task automatic rd_none(input string tag);
    bus(tag, 1'b1, 1'b1, 8'h00, 8'h00, -1);
    check({tag, " data"}, data_out, 8'hFF);
    check({tag, " oe_x"}, data_oe_x, 1'b1);
  endtask
  task automatic init_sel(input logic [7:0] r);
    bus("rel", 1'b0, 1'b0, 8'h00, 8'h00, -1);
    bus("init", 1'b0, 1'b0, 8'h10, 8'h00, -1);
    wr(r);
  endtask
  task automatic get_sel(input logic [7:0] s);
    bus("get", 1'b0, 1'b1, 8'hFF, 8'h00, -1);
    wr(s);
  endtask
  task automatic pulse_irq(input logic [7:0] bits);
    @(negedge clk);
    irq_set = bits;
    @(negedge clk);
    irq_set = 8'h00;
    @(negedge clk);
  endtask
  initial begin
    #10000000;
    $display("FAIL global timeout");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst data_out", data_out, 8'hFF);
    check("rst oe_x", data_oe_x, 1'b1);
    check("rst int_x", int_x, 1'b1);
    check("rst rgb", rgb_comp_x, 1'b0);
    check("rst int_ext", int_ext_x, 1'b0);
    check("rst video_oe_x", video_oe_x, 1'b0);
    check("rst hd_sd", hd_sd_x, 1'b1);
    init_sel(8'h03);
    wr(8'h02);
    get_sel(8'h20);
    rd("id", 8'h88);
    get_sel(8'h30);
    rd_none("slot mismatch");
    get_sel(8'h22);
    rd_none("bad sel");
    slot_x_int_x = 1'b1;
    init_sel(8'h41);
    rd_none("no slot");
    slot_x_int_x = 1'b0;
    pulse_irq(8'h04);
    check("irq2 int_x", int_x, 1'b0);
    init_sel(8'h41);
    rd("st set", 8'hFB);
    wr(8'h04);
    check("w1c int_x", int_x, 1'b1);
    rd("st clr", 8'hFF);
    init_sel(8'h77);
    rd("unknown init", 8'hFF);
    init_sel(8'h42);
    wr(8'h00);
    rd("mask", 8'h00);
    pulse_irq(8'h01);
    check("masked int_x", int_x, 1'b1);
    init_sel(8'h41);
    rd("masked st", 8'hFE);
    wr(8'h01);
    init_sel(8'h42);
    wr(8'hFF);
    rd("mask back", 8'hFF);
    pulse_irq(8'h02);
    init_sel(8'h41);
    bus("race", 1'b1, 1'b0, 8'h02, 8'h02, -1);
    rd("race st", 8'hFD);
    wr(8'h02);
    rd("race clr", 8'hFF);
    video_format = 8'd3;
    @(negedge clk);
    check("fmt early int_x", int_x, 1'b1);
    repeat (3) @(negedge clk);
    check("fmt int_x", int_x, 1'b0);
    check("fmt3 hd_sd", hd_sd_x, 1'b1);
    init_sel(8'h41);
    rd("fmt st", 8'hDF);
    wr(8'h20);
    check("fmt clr int_x", int_x, 1'b1);
    video_format = 8'd1;
    @(negedge clk);
    check("fmt1 hd_sd", hd_sd_x, 1'b0);
    video_format = 8'd2;
    @(negedge clk);
    check("fmt2 hd_sd", hd_sd_x, 1'b0);
    get_sel(8'h21);
    wr(8'h00);
    wr(8'h01);
    check("cs rgb_x", rgb_comp_x, 1'b1);
    rd("cs", 8'h00);
    wr(8'h04);
    check("cs4 rgb_x", rgb_comp_x, 1'b0);
    rd("cs rgb", 8'h04);
    get_sel(8'h21);
    wr(8'h10);
    wr(8'h09);
    check("vctrl int_ext", int_ext_x, 1'b1);
    check("vctrl video_oe_x", video_oe_x, 1'b0);
    wr(8'h00);
    check("vctrl0 int_ext", int_ext_x, 1'b0);
    check("vctrl0 video_oe_x", video_oe_x, 1'b1);
    rd("vctrl", 8'h00);
    wr(8'h01);
    check("vctrl1 int_ext", int_ext_x, 1'b1);
    get_sel(8'h21);
    wr(8'h55);
    rd("vid unknown", 8'hFF);
    get_sel(8'h23);
    wr(8'h07);
    rd("serial 7", 8'h30);
    get_sel(8'h23);
    wr(8'h00);
    rd("serial 0", 8'h4D);
    get_sel(8'h23);
    wr(8'h06);
    rd("serial 6", 8'h31);
    get_sel(8'h20);
    ax_d = 1'b1;
    r_wx = 1'b1;
    data_in_x = 8'hFF;
    repeat (2) @(negedge clk);
    clk_rw = 1'b1;
    repeat (6) @(negedge clk);
    check("abort pre oe_x", data_oe_x, 1'b0);
    reset = 1'b1;
    #1;
    check("abort oe_x", data_oe_x, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clk_rw = 1'b0;
    repeat (4) @(negedge clk);
    check("abort data_out", data_out, 8'hFF);
    check("abort int_ext", int_ext_x, 1'b0);
    check("abort video_oe_x", video_oe_x, 1'b0);
    get_sel(8'h00);
    rd("id slot0", 8'h88);
`ifdef MONITOR_SLOT_IF_TIMEOUT_EN
    repeat (50010) @(negedge clk);
    check("wd oe_x", data_oe_x, 1'b1);
    rd_none("wd idle");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/monitor_slot_if.md
MONITOR_SLOT_IF -- requirements
Module: monitor_slot_if

Interface
REQ-001 Parameter ID_VALUE, default 8'h88, value returned on an ID read.
REQ-002 Parameter SERIAL_LEN, default 7, number of serial-number bytes; range 1..16.
REQ-003 Parameter NUM_IRQ, default 8, number of interrupt sources; range 1..8.
REQ-004 Parameter FMT_W, default 8, width of video_format.
REQ-005 Parameter TIMEOUT_CYC, default 50000, watchdog length in clk_50mhz_in cycles.
REQ-006 clk_50mhz_in  in  1  sole clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 clk_rw  in  1  bus strobe; asynchronous, sampled.
REQ-009 ax_d  in  1  0 = address cycle, 1 = data cycle.
REQ-010 r_wx  in  1  1 = read, 0 = write.
REQ-011 slot_x_int_x  in  1  active-low slot-init select.
REQ-012 data_in_x  in  8  bus data, inverted.
REQ-013 irq_set  in  NUM_IRQ  one-cycle interrupt set pulses.
REQ-014 video_format  in  FMT_W  detected format; 0 = no signal.
REQ-015 data_out  out  8  read data.
REQ-016 data_oe_x  out  1  active-low bus drive enable.
REQ-017 int_x  out  1  active-low interrupt.
REQ-018 rgb_comp_x, int_ext_x, video_oe_x, hd_sd_x  out  1 each  video control.

Function
REQ-019 clk_rw, ax_d, r_wx, slot_x_int_x and data_in_x shall pass a 2-FF synchroniser; a bus cycle shall begin on the synchronised clk_rw rising edge, and inputs shall be sampled one cycle later.
REQ-020 data_in shall be ~data_in_x; all decode shall use data_in.
REQ-021 FSM states: IDLE, GET_REG, INIT_REG, INIT_DATA, SUB_REG, SUB_DATA, WAIT_NEXT.
REQ-022 Address 8'hFF with r_wx=1 from any state shall go to GET_REG with data_oe cleared.
REQ-023 Address 8'h10 with r_wx=0 and slot_x_int_x=0 shall go IDLE->INIT_REG.
REQ-024 In GET_REG, data {slot_no[3:0],4'hN} shall select N=0 ID, 1 video, 3 serial and go to SUB_REG; any other value shall go to WAIT_NEXT.
REQ-025 An ID read shall return ID_VALUE.
REQ-026 A serial read of index i<SERIAL_LEN shall return serial[i]; i>=SERIAL_LEN shall return 8'h30.
REQ-027 Init registers: 0x03 slot_no (W); 0x41 irq status (R = ~pending, W1C); 0x42 irq mask (R/W, 1 = enabled).
REQ-028 Video registers: 0x00 colour space (write 0x04 -> rgb_comp_x=0, otherwise 1); 0x10 control (bit0 -> int_ext_x, bit3 -> video_oe).
REQ-029 data_oe_x shall be ~(data_oe & r_wx & ax_d & ~reset), and data_out shall be valid 1 cycle after the sampled strobe.
REQ-030 A video_format change held stable for 2 consecutive cycles shall set pending bit 5, when NUM_IRQ>5.
REQ-031 int_x shall be 0 iff (pending & mask) != 0.
REQ-032 A same-cycle irq_set and W1C on one bit shall leave that bit set.
REQ-033 hd_sd_x shall be 0 iff video_format is 1 or 2.
REQ-034 An unused or unknown register shall read 8'hFF, and a write to one shall be ignored.

Reset
REQ-035 On reset: FSM=IDLE, data_out=8'hFF, data_oe=0, slot_no=0, pending=0, mask=all ones, rgb_comp_x=0, int_ext_x=0, video_oe=1, int_x=1.
REQ-036 A reset asserted mid-transfer shall abort the transfer, and data_oe_x shall be 1 in the same cycle.

Configuration
REQ-037 With MONITOR_SLOT_IF_TIMEOUT_EN defined, a non-IDLE FSM that sees no strobe for TIMEOUT_CYC cycles shall return to IDLE and clear data_oe.
REQ-038 Without MONITOR_SLOT_IF_TIMEOUT_EN, no watchdog shall exist and the FSM shall wait indefinitely.

Structure
REQ-039 Package monitor_slot_pkg shall hold the FSM state enum, the command and register address constants, and the default serial bytes.
REQ-040 The sub-module monitor_slot_irq shall hold the pending/mask/W1C logic and format-change detection.

Verification
REQ-041 Init write 0x03 = 0x02, then addr 0xFF, data 0x20 read -> 0x88.
REQ-042 Pulse irq_set[2] -> int_x=0 and 0x41 reads 0xFB; write 0x41 = 0x04 -> int_x=1 and reads 0xFF.
REQ-043 Write mask 0x42 = 0x00 and pulse irq_set[0] -> int_x stays 1, and 0x41 reads 0xFE.
REQ-044 Change video_format 0->3 -> pending bit 5 set after 4 cycles, and hd_sd_x=1.
REQ-045 Serial read with SERIAL_LEN=7 at index 7 -> 0x30.
REQ-046 With the watchdog macro defined, stall 50000 cycles in SUB_REG -> FSM returns to IDLE; assert reset mid-read -> data_oe_x=1.
